// File: rtl/snn_load_sink.sv
// Receive end of the SNN load stream: decodes START/FILTER/IFMAP/DONE tokens into
// filter and per-timestep ifmap memories, with registered read ports and load status.
module snn_ifmap_bank #(
  parameter int DEPTH = 625,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic          wd,
  input  logic          rd_sel,
  input  logic [AW-1:0] ra,
  output logic          rd
);
  logic mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;

  // Unselected banks read as 0 so the top can OR the bank outputs together.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rd <= 1'b0;
    else        rd <= rd_sel ? mem[ra] : 1'b0;
endmodule

module snn_load_sink #(
  parameter int WIDTH_data = 8,
  parameter int WIDTH_addr = 12,
  parameter int DEPTH_F    = 5,
  parameter int DEPTH_I    = 25,
  parameter int NUM_TS     = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_kind,
  input  logic [WIDTH_addr-1:0]  in_addr,
  input  logic [WIDTH_data-1:0]  in_data,
  input  logic [1:0]             in_ts,
  input  logic [4:0]             f_rd_addr,
  output logic [WIDTH_data-1:0]  f_rd_data,
  input  logic [1:0]             i_rd_ts,
  input  logic [9:0]             i_rd_addr,
  output logic                   i_rd_data,
  output logic                   loading,
  output logic                   load_done,
  output logic                   load_ok,
  output logic                   err,
  output logic [4:0]             filt_count,
  output logic [NUM_TS-1:0][9:0] ifmap_count
);
  localparam int F_N = DEPTH_F * DEPTH_F;
  localparam int I_N = DEPTH_I * DEPTH_I;
  localparam logic [WIDTH_addr-1:0] F_LIM  = WIDTH_addr'(F_N);
  localparam logic [WIDTH_addr-1:0] I_LIM  = WIDTH_addr'(I_N);
  localparam logic [4:0]            F_RLIM = 5'(F_N);
  localparam logic [9:0]            I_RLIM = 10'(I_N);
  localparam logic [1:0]            TS_MAX = 2'(NUM_TS);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;
  typedef enum logic [1:0] {K_START, K_FILTER, K_IFMAP, K_DONE} kind_t;

  state_t state;
  kind_t  kind;
  logic   xfer, f_ok, i_ok, f_we, full;
  logic [NUM_TS-1:0] i_we, i_sel, bank_rd;
  logic [WIDTH_data-1:0] fmem [F_N];

  assign kind    = kind_t'(in_kind);
  assign xfer    = in_valid && in_ready;
  assign f_ok    = in_addr < F_LIM;
  assign i_ok    = (in_addr < I_LIM) && (in_ts != 2'd0) && (in_ts <= TS_MAX);
  assign f_we    = xfer && (state == S_LOAD) && (kind == K_FILTER) && f_ok;
  assign loading = (state == S_LOAD);

  always_comb begin
    full = (filt_count == 5'(F_N));
    for (int t = 0; t < NUM_TS; t++) begin
      i_we[t]  = xfer && (state == S_LOAD) && (kind == K_IFMAP) && i_ok && (in_ts == 2'(t + 1));
      i_sel[t] = (i_rd_addr < I_RLIM) && (i_rd_ts == 2'(t + 1));
      full     = full && (ifmap_count[t] == 10'(I_N));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      in_ready    <= 1'b0;
      load_done   <= 1'b0;
      load_ok     <= 1'b0;
      err         <= 1'b0;
      filt_count  <= '0;
      ifmap_count <= '0;
    end else begin
      in_ready <= 1'b1;
      if (xfer) begin
        case (state)
          S_IDLE, S_DONE: begin
            if (kind == K_START) begin
              state       <= S_LOAD;
              load_done   <= 1'b0;
              load_ok     <= 1'b0;
              err         <= 1'b0;
              filt_count  <= '0;
              ifmap_count <= '0;
            end else begin
              err <= 1'b1;
            end
          end
          S_LOAD: begin
            case (kind)
              K_START: begin
                err         <= 1'b1;
                filt_count  <= '0;
                ifmap_count <= '0;
              end
              K_FILTER: begin
                if (!f_ok)                 err        <= 1'b1;
                else if (filt_count != '1) filt_count <= filt_count + 5'd1;
              end
              K_IFMAP: begin
                if (!i_ok) err <= 1'b1;
                for (int t = 0; t < NUM_TS; t++)
                  if (i_we[t] && ifmap_count[t] != '1)
                    ifmap_count[t] <= ifmap_count[t] + 10'd1;
              end
              default: begin
                // Counts are frozen from here on, so load_ok can be latched now.
                state     <= S_DONE;
                load_done <= 1'b1;
                load_ok   <= full;
              end
            endcase
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk)
    if (f_we) fmem[in_addr[4:0]] <= in_data;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) f_rd_data <= '0;
    else        f_rd_data <= (f_rd_addr < F_RLIM) ? fmem[f_rd_addr] : '0;

  snn_ifmap_bank #(.DEPTH(I_N), .AW(10)) u_bank [NUM_TS-1:0] (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (i_we),
    .wa     (in_addr[9:0]),
    .wd     (in_data[0]),
    .rd_sel (i_sel),
    .ra     (i_rd_addr),
    .rd     (bank_rd)
  );

  assign i_rd_data = |bank_rd;
endmodule

// File: tb/tb_snn_load_sink.sv
// Directed + randomized bench for snn_load_sink against a token-level reference model.
module tb_snn_load_sink;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [1:0]  in_kind = '0, in_ts = '0, i_rd_ts = '0;
  logic [11:0] in_addr = '0;
  logic [7:0]  in_data = '0, f_rd_data;
  logic [4:0]  f_rd_addr = '0, filt_count;
  logic [9:0]  i_rd_addr = '0;
  logic        i_rd_data, loading, load_done, load_ok, err;
  logic [1:0][9:0] ifmap_count;

  always #5 clk = ~clk;

  snn_load_sink dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_addr(in_addr), .in_data(in_data), .in_ts(in_ts),
    .f_rd_addr(f_rd_addr), .f_rd_data(f_rd_data), .i_rd_ts(i_rd_ts),
    .i_rd_addr(i_rd_addr), .i_rd_data(i_rd_data), .loading(loading),
    .load_done(load_done), .load_ok(load_ok), .err(err),
    .filt_count(filt_count), .ifmap_count(ifmap_count)
  );

  // Reference model: mode 0=idle 1=load 2=done, counts kept unbounded.
  int   mode = 0, fc = 0, ic [2] = '{0, 0};
  bit   err_m = 0, ready_m = 0;
  logic [7:0] fm [25];
  bit   im [2][625];
  int   vectors = 0, miscompares = 0;

  function automatic int sat(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_token(int k, int a, int d, int t);
    if (mode != 1) begin
      if (k == 0) begin mode = 1; fc = 0; ic = '{0, 0}; err_m = 0; end
      else err_m = 1;
    end else begin
      case (k)
        0: begin err_m = 1; fc = 0; ic = '{0, 0}; end
        1: if (a < 25) begin fm[a] = 8'(d); fc++; end else err_m = 1;
        2: if (t >= 1 && t <= 2 && a < 625) begin im[t-1][a] = d[0]; ic[t-1]++; end
           else err_m = 1;
        default: mode = 2;
      endcase
    end
  endtask

  task automatic chk_status();
    logic [19:0] eic;
    eic = {10'(sat(ic[1], 1023)), 10'(sat(ic[0], 1023))};
    chk("in_ready", in_ready, ready_m);
    chk("loading", loading, mode == 1);
    chk("load_done", load_done, mode == 2);
    chk("load_ok", load_ok, mode == 2 && fc == 25 && ic[0] == 625 && ic[1] == 625);
    chk("err", err, err_m);
    chk("filt_count", filt_count, sat(fc, 31));
    chk("ifmap_count", ifmap_count, eic);
  endtask

  // One clock: present a token and read addresses, then check reads and status.
  task automatic step(bit v, int k, int a = 0, int d = 0, int t = 0,
                      int fra = 31, int its = 0, int ira = 1023);
    logic [7:0] ef;
    bit ei;
    ef = (fra < 25) ? fm[fra] : 8'd0;
    ei = (its >= 1 && its <= 2 && ira < 625) ? im[its-1][ira] : 1'b0;
    in_valid = v; in_kind = 2'(k); in_addr = 12'(a); in_data = 8'(d); in_ts = 2'(t);
    f_rd_addr = 5'(fra); i_rd_ts = 2'(its); i_rd_addr = 10'(ira);
    @(posedge clk); #1;
    if (v && ready_m) model_token(k, a, d, t);
    ready_m = 1;
    in_valid = 1'b0;
    chk("f_rd_data", f_rd_data, ef);
    chk("i_rd_data", i_rd_data, ei);
    chk_status();
  endtask

  task automatic ifmaps();
    for (int a = 0; a < 625; a++) step(1, 2, a, a & 1, 1);
    for (int a = 0; a < 625; a++) step(1, 2, a, ~a & 1, 2);
  endtask

  initial begin
    int k, a, d, t, r;
    #2;
    chk_status();
    chk("rst_f_rd", f_rd_data, 0);
    chk("rst_i_rd", i_rd_data, 0);
    @(posedge clk); #1;
    chk("ready_in_reset", in_ready, 0);
    rst_n = 1'b1;
    step(0, 0);

    // FILTER while idle
    step(1, 1, 3, 77);
    chk("idle_err", err, 1);
    chk("idle_loading", loading, 0);

    // full load
    step(1, 0);
    for (int i = 0; i < 25; i++) step(1, 1, i, i * 3);
    ifmaps();
    step(1, 3);
    chk("full_ok", load_ok, 1);
    chk("full_err", err, 0);
    step(0, 0, 0, 0, 0, 7);
    chk("f7", f_rd_data, 21);
    step(0, 0, 0, 0, 0, 31, 1, 4);
    chk("i1_4", i_rd_data, 0);
    step(0, 0, 0, 0, 0, 31, 2, 4);
    chk("i2_4", i_rd_data, 1);

    // reload keeps memories
    step(1, 0);
    chk("reload_done", load_done, 0);
    chk("reload_fc", filt_count, 0);
    step(0, 0, 0, 0, 0, 7);
    chk("reload_f7", f_rd_data, 21);

    // address / timestep errors in LOAD
    step(1, 1, 25, 8'h55);
    chk("f25_err", err, 1);
    chk("f25_fc", filt_count, 0);
    step(1, 2, 4, 1, 3);
    chk("ts3_err", err, 1);
    chk("ts3_ic", ifmap_count, 0);

    // read-before-write collision
    step(1, 1, 3, 5);
    step(1, 1, 3, 9, 0, 3);
    chk("coll_old", f_rd_data, 5);
    step(0, 0, 0, 0, 0, 3);
    chk("coll_new", f_rd_data, 9);

    // short load
    step(1, 0);
    for (int i = 0; i < 24; i++) step(1, 1, i, i * 3);
    ifmaps();
    step(1, 3);
    chk("short_done", load_done, 1);
    chk("short_ok", load_ok, 0);
    chk("short_fc", filt_count, 24);

    // asynchronous reset mid-load
    step(1, 0);
    for (int i = 0; i < 10; i++) step(1, 1, i, i * 3);
    #2 rst_n = 1'b0;
    mode = 0; fc = 0; ic = '{0, 0}; err_m = 0; ready_m = 0;
    #1;
    chk_status();
    chk("arst_f_rd", f_rd_data, 0);
    @(posedge clk); #1;
    chk("arst_ready", in_ready, 0);
    rst_n = 1'b1;
    step(0, 0);
    step(1, 0);
    chk("restart_fc", filt_count, 0);

    // filter count saturation
    for (int i = 0; i < 40; i++) step(1, 1, i % 25, $urandom_range(0, 255));
    chk("sat_fc", filt_count, 31);
    step(1, 3);
    chk("sat_ok", load_ok, 0);
    step(1, 0);

    // randomized tokens and reads
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      k = (r < 4) ? 0 : (r < 8) ? 3 : (r < 50) ? 1 : 2;
      a = (k == 1) ? $urandom_range(0, 31) : $urandom_range(0, 700);
      d = $urandom_range(0, 255);
      t = $urandom_range(1, 2);
      if ($urandom_range(0, 9) == 0) t = $urandom_range(0, 1) * 3;
      step($urandom_range(0, 9) < 8, k, a, d, t,
           $urandom_range(0, 31), $urandom_range(0, 3), $urandom_range(0, 700));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
